// File: rtl/wb_commit_tracer_if.sv
// ---------------------------------------------------------------------------
// wb_commit_tracer_if
//
// Purpose : groups the signals a commit tracer observes on the core
//           (writeback commit, memory-stage store, hazard-unit stall/flush)
//           together with the valid/ready drain port of its event FIFO.
//
// Signals :
//   RegWriteW  / WriteRegW / ResultW      writeback register commit
//   MemWriteM  / ALUOutM   / WriteDataM   memory-stage store
//   StallF     / FlushE                   hazard-unit status
//   out_valid  / out_ready / out_data     FIFO head (66-bit entry)
//   out_level                             FIFO occupancy
//
// Modports:
//   master : the side that produces the core signals and consumes entries
//            (core probe plus drain logic, or a testbench)
//   slave  : the tracer itself
// ---------------------------------------------------------------------------
interface wb_commit_tracer_if #(
    parameter int DEPTH = 16
) ();
    logic                     RegWriteW;
    logic [4:0]               WriteRegW;
    logic [31:0]              ResultW;
    logic                     MemWriteM;
    logic [31:0]              ALUOutM;
    logic [31:0]              WriteDataM;
    logic                     StallF;
    logic                     FlushE;
    logic                     out_valid;
    logic                     out_ready;
    logic [65:0]              out_data;
    logic [$clog2(DEPTH):0]   out_level;

    modport master (
        output RegWriteW, WriteRegW, ResultW,
        output MemWriteM, ALUOutM, WriteDataM,
        output StallF, FlushE,
        output out_ready,
        input  out_valid, out_data, out_level
    );

    modport slave (
        input  RegWriteW, WriteRegW, ResultW,
        input  MemWriteM, ALUOutM, WriteDataM,
        input  StallF, FlushE,
        input  out_ready,
        output out_valid, out_data, out_level
    );
endinterface

// File: rtl/wb_commit_tracer.sv
// ---------------------------------------------------------------------------
// wb_commit_tracer
//
// Purpose : passive observer of the pipeline's writeback and memory stages.
//           Every architectural register commit (writes to $0 excluded) is
//           pushed into a FIFO as a 66-bit entry {kind, tag, data}; the
//           FIFO is drained through a valid/ready port. Free-running cycle,
//           stall, flush and commit counters are kept alongside.
//
// Entry format:
//   [65:64] kind : 2'b01 register commit, 2'b10 store
//   [63:32] tag  : zero-extended destination register, or store address
//   [31:0]  data : result value, or store data
//
// Ports:
//   ref_clk       in   core clock, rising-edge active
//   reset         in   asynchronous active-high reset, clears all state
//   clear         in   synchronous clear of FIFO, counters and overflow
//   bus           slave modport of wb_commit_tracer_if (core signals + drain)
//   overflow      out  sticky: an event was dropped because the FIFO was full
//   cycle_count   out  edges since reset/clear
//   stall_count   out  edges with StallF=1
//   flush_count   out  edges with FlushE=1
//   commit_count  out  register events accepted into the FIFO
//
// Optional feature:
//   `define WB_COMMIT_TRACER_STORE_TRACE_EN to also capture stores
//   (MemWriteM) as kind 2'b10 entries. When both a register commit and a
//   store arrive on one edge the register entry goes first; the store is
//   only kept when two slots are free. Without the macro the store inputs
//   are ignored.
//
// Parameters:
//   DEPTH  FIFO entries, power of two, >= 2
//   CNT_W  counter width; all counters wrap
// ---------------------------------------------------------------------------
module wb_commit_tracer #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic             ref_clk,
    input  logic             reset,
    input  logic             clear,
    wb_commit_tracer_if.slave bus,
    output logic             overflow,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] commit_count
);

    localparam int AW = $clog2(DEPTH);
    // One extra pointer bit distinguishes full from empty.
    localparam int PW = AW + 1;

    localparam logic [1:0] KIND_REG   = 2'b01;
    localparam logic [1:0] KIND_STORE = 2'b10;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic [CNT_W-1:0] commit_q, commit_d;

    // Entry storage carries no reset: only the pointers decide what is live.
    logic [65:0]      mem_q [DEPTH];

    // -----------------------------------------------------------------------
    // Derived FIFO status
    // -----------------------------------------------------------------------
    logic [PW-1:0]    level;
    logic             not_empty;
    logic             pop;
    logic [PW-1:0]    free_slots;

    assign level      = wr_ptr_q - rd_ptr_q;
    assign not_empty  = (level != '0);
    assign pop        = not_empty && bus.out_ready;
    // A pop on this edge frees its slot for a push on the same edge.
    assign free_slots = PW'(DEPTH) - level + PW'(pop);

    // -----------------------------------------------------------------------
    // Event detection and entry formatting
    // -----------------------------------------------------------------------
    logic        reg_ev;
    logic        st_ev;
    logic [65:0] reg_entry;
    logic [65:0] st_entry;

    assign reg_ev    = bus.RegWriteW && (bus.WriteRegW != 5'd0);
    assign reg_entry = {KIND_REG, 27'd0, bus.WriteRegW, bus.ResultW};

`ifdef WB_COMMIT_TRACER_STORE_TRACE_EN
    assign st_ev    = bus.MemWriteM;
    assign st_entry = {KIND_STORE, bus.ALUOutM, bus.WriteDataM};
`else
    // Store inputs are observed but deliberately discarded in this build.
    logic unused_store_inputs;
    assign unused_store_inputs = ^{bus.MemWriteM, bus.ALUOutM, bus.WriteDataM, KIND_STORE};
    assign st_ev    = 1'b0;
    assign st_entry = '0;
`endif

    // -----------------------------------------------------------------------
    // Push arbitration
    // The register entry is always considered first; a store then needs a
    // slot beyond the one the register entry may have taken.
    // -----------------------------------------------------------------------
    logic reg_push;
    logic st_push;
    logic drop;

    always_comb begin
        reg_push = 1'b0;
        st_push  = 1'b0;
        drop     = 1'b0;
        if (reg_ev) begin
            if (free_slots >= PW'(1)) begin
                reg_push = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
        if (st_ev) begin
            if (free_slots >= (reg_push ? PW'(2) : PW'(1))) begin
                st_push = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
    end

    // Write addresses: the store lands one slot after a same-edge register entry.
    logic [AW-1:0] reg_addr;
    logic [AW-1:0] st_addr;

    assign reg_addr = wr_ptr_q[AW-1:0];
    assign st_addr  = wr_ptr_q[AW-1:0] + AW'(reg_push);

    // -----------------------------------------------------------------------
    // Next-state logic; clear overrides every push, pop and count.
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q + PW'(reg_push) + PW'(st_push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        overflow_d = overflow_q | drop;
        cycle_d    = cycle_q + CNT_W'(1);
        stall_d    = stall_q + CNT_W'(bus.StallF);
        flush_d    = flush_q + CNT_W'(bus.FlushE);
        commit_d   = commit_q + CNT_W'(reg_push);
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
            cycle_d    = '0;
            stall_d    = '0;
            flush_d    = '0;
            commit_d   = '0;
        end
    end

    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            cycle_q    <= '0;
            stall_q    <= '0;
            flush_q    <= '0;
            commit_q   <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            cycle_q    <= cycle_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
            commit_q   <= commit_d;
        end
    end

    // Entry storage: written only for accepted events.
    always_ff @(posedge ref_clk) begin
        if (!clear && !reset) begin
            if (reg_push) begin
                mem_q[reg_addr] <= reg_entry;
            end
            if (st_push) begin
                mem_q[st_addr] <= st_entry;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // Head entry is combinational and masked to zero when empty, so it reads
    // zero as soon as an asynchronous reset clears the pointers.
    // -----------------------------------------------------------------------
    assign bus.out_valid  = not_empty;
    assign bus.out_data   = not_empty ? mem_q[rd_ptr_q[AW-1:0]] : 66'd0;
    assign bus.out_level  = level;

    assign overflow     = overflow_q;
    assign cycle_count  = cycle_q;
    assign stall_count  = stall_q;
    assign flush_count  = flush_q;
    assign commit_count = commit_q;

endmodule

// File: doc/wb_commit_tracer.md
Name: wb_commit_tracer

Overview:
- Passive observer attached to the writeback and memory stage outputs of the 5-stage 32-bit pipeline core.
- Captures every architectural register commit, and optionally every store, into a FIFO with timestamps removed. The bench or debug logic drains the FIFO through a valid/ready port.
- Also keeps a cycle counter, a stall-cycle counter and a flush counter, so the bench can check pipeline behaviour without probing internal stage registers.

Parameters:
- DEPTH, 16, number of FIFO entries; must be a power of two, at least 2.
- CNT_W, 32, width of the cycle, stall, flush and commit counters.

Ports:
- ref_clk  in  1  core clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- clear  in  1  synchronous clear of the FIFO, counters and overflow.
- RegWriteW  in  1  writeback register-write enable.
- WriteRegW  in  5  writeback destination register.
- ResultW  in  32  writeback result value.
- MemWriteM  in  1  memory-stage store enable (used only with the optional feature).
- ALUOutM  in  32  store address.
- WriteDataM  in  32  store data.
- StallF  in  1  fetch stall from the hazard unit.
- FlushE  in  1  execute flush from the hazard unit.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head entry.
- out_data  out  66  head entry: [65:64] kind, [63:32] tag, [31:0] data.
- out_level  out  log2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky flag: an event was dropped.
- cycle_count  out  CNT_W  cycles since reset or clear.
- stall_count  out  CNT_W  cycles with StallF=1.
- flush_count  out  CNT_W  cycles with FlushE=1.
- commit_count  out  CNT_W  register events accepted into the FIFO.

Behaviour:
- Reset is asynchronous. While reset=1, all outputs read 0: out_valid, out_level, overflow, every counter, and out_data.
- Register event: RegWriteW=1 and WriteRegW!=0 sampled at a rising edge. Writes to $0 are ignored, both for capture and for commit_count.
- Register entry encoding:
  - kind=2'b01
  - tag = zero-extended WriteRegW
  - data = ResultW
- Latency is 1 cycle: an event sampled at edge N produces out_valid=1 and updated out_level immediately after edge N.
- Handshake:
  - A pop occurs at an edge where out_valid=1 and out_ready=1.
  - out_data is the combinational head entry. It is forced to 0 when out_valid=0.
  - out_data is stable while out_valid=1 and out_ready=0.
- Free slots are computed as DEPTH - out_level + pop. A pop and a push on the same edge when full both succeed; the level stays at DEPTH.
- Full with no pop: the event is dropped, overflow is set, and commit_count does not increment.
- Empty with out_ready=1: no pop occurs and the state is unchanged.
- Pointers wrap modulo DEPTH. Occupancy is tracked with an extra pointer bit, so full and empty are unambiguous.
- Counters:
  - cycle_count increments every edge.
  - stall_count increments on edges with StallF=1.
  - flush_count increments on edges with FlushE=1.
  - All counters wrap modulo 2^CNT_W; none saturate.
- clear=1 at an edge has priority over every push, pop and count on that edge. Afterwards the FIFO is empty, all counters are 0, and overflow is 0.
- Reset asserted mid-drain: the FIFO contents are discarded immediately, with no partial pop.
- The block never drives any core signal. It is a pure observer.

Optional Feature:
- Macro: WB_COMMIT_TRACER_STORE_TRACE_EN.
- Defined:
  - MemWriteM=1 at an edge is also captured as an entry with kind=2'b10, tag=ALUOutM, data=WriteDataM.
  - If a register event and a store occur on the same edge, the register entry is written first, then the store entry. Both are accepted only if at least 2 slots are free.
  - If exactly 1 slot is free, the register entry is kept, the store is dropped, and overflow is set.
  - Stores never increment commit_count.
- Undefined: MemWriteM, ALUOutM and WriteDataM are ignored, and kind 2'b10 never appears.

Test Plan:
- Reset, then commit addi $8=0x00000005 (RegWriteW=1, WriteRegW=8, ResultW=5) with out_ready=0 -> next cycle out_valid=1, out_data=0x1_00000008_00000005, out_level=1, commit_count=1.
- Assert RegWriteW=1 with WriteRegW=0 and ResultW=0xDEADBEEF -> no entry is added; out_level and commit_count are unchanged.
- Push 17 register events with DEPTH=16 and out_ready=0 -> out_level=16, overflow=1, commit_count=16. Hold out_ready=1 and push on the same edge when full -> out_level stays 16 and the head advances.
- Drive StallF=1 for 3 cycles and FlushE=1 for 2 cycles across 10 cycles after reset -> stall_count=3, flush_count=2, cycle_count=10. Pulse clear -> all counters 0 on the next cycle.
- Assert reset asynchronously mid-cycle while out_level=5 -> out_valid=0, out_level=0 and out_data=0 without waiting for an edge.
- With WB_COMMIT_TRACER_STORE_TRACE_EN: a register event ($9=7) and a store (addr 0x40, data 0x1234) on the same edge with an empty FIFO -> two entries in order, 0x1_00000009_00000007 then 0x2_00000040_00001234. Repeat with 1 free slot -> the store is dropped and overflow=1.
